uparc_lsu: RTL and testbench

Load/store unit between the memory access stage and the CPU data bus. Accepts one-cycle load/store commands, checks natural alignment, and steers bytes and halfwords onto 32-bit bus lanes with byte enables. Runs a single outstanding address/data-phase transaction and holds `lsu_busy` until read data is registered. Returns right-justified, zero-extended read data; sign extension is done by the consumer.

---
 rtl/uparc_lsu_pkg.sv | 38 +++
 rtl/uparc_lsu_lanes.sv | 66 ++++++
 rtl/uparc_lsu.sv | 119 +++++++++++
 tb/tb_uparc_lsu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uparc_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uparc_lsu_pkg
// Description : Shared constants for the uparc load/store unit. Defines the
//               bus widths, the command encodings, the FSM state encodings
//               and the natural-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uparc_lsu_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // lsu_cmd encodings
  localparam logic [1:0] LSU_IDLE  = 2'd0;
  localparam logic [1:0] LSU_BYTE  = 2'd1;
  localparam logic [1:0] LSU_HWORD = 2'd2;
  localparam logic [1:0] LSU_WORD  = 2'd3;

  // FSM state encodings
  localparam logic [1:0] LSU_ST_IDLE = 2'd0;
  localparam logic [1:0] LSU_ST_CMD  = 2'd1;
  localparam logic [1:0] LSU_ST_DATA = 2'd2;

  // Natural alignment: bytes always, halfwords on even, words on 4-byte.
  function automatic logic lsu_aligned(input logic [1:0] cmd, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    case (cmd)
      LSU_HWORD: ok = (off[0] == 1'b0);
      LSU_WORD:  ok = (off == 2'b00);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uparc_lsu_lanes.sv
`default_nettype none
// ============================================================================
// Module      : uparc_lsu_lanes
// Description : Combinational little-endian lane logic for the LSU.
//               Store side: replicates the right-justified store data onto
//               all lanes and derives byte enables from size and offset.
//               Load side: selects the addressed lane(s) of the bus word and
//               right-justifies them with zero extension.
// Ports       : st_size/st_off/st_wdata -> bus_wdata/bus_ben (store steering)
//               ld_size/ld_off/ld_bus_rdata -> ld_rdata (load extraction)
// Revision    : 1.0 - initial release
// ============================================================================
module uparc_lsu_lanes
  import uparc_lsu_pkg::*;
(
  input  logic [1:0]            st_size,
  input  logic [1:0]            st_off,
  input  logic [DATA_WIDTH-1:0] st_wdata,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_ben,
  input  logic [1:0]            ld_size,
  input  logic [1:0]            ld_off,
  input  logic [DATA_WIDTH-1:0] ld_bus_rdata,
  output logic [DATA_WIDTH-1:0] ld_rdata
);

  logic [DATA_WIDTH-1:0] w_shifted;

  always_comb begin
    bus_wdata = st_wdata;
    bus_ben   = 4'b0000;
    case (st_size)
      LSU_BYTE: begin
        bus_wdata = {4{st_wdata[7:0]}};
        bus_ben   = 4'b0001 << st_off;
      end
      LSU_HWORD: begin
        bus_wdata = {2{st_wdata[15:0]}};
        bus_ben   = st_off[1] ? 4'b1100 : 4'b0011;
      end
      LSU_WORD: begin
        bus_wdata = st_wdata;
        bus_ben   = 4'b1111;
      end
      default: begin
        bus_wdata = st_wdata;
        bus_ben   = 4'b0000;
      end
    endcase
  end

  // Offset is already known aligned, so a byte-granular right shift brings
  // the addressed lane(s) down to bit 0 for every size.
  assign w_shifted = ld_bus_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_rdata = w_shifted;
    case (ld_size)
      LSU_BYTE:  ld_rdata = {24'd0, w_shifted[7:0]};
      LSU_HWORD: ld_rdata = {16'd0, w_shifted[15:0]};
      default:   ld_rdata = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uparc_lsu.sv
`default_nettype none
// ============================================================================
// Module      : uparc_lsu
// Description : Load/store unit between the memory stage and the CPU data
//               bus. Single outstanding address/data-phase transaction,
//               natural-alignment check, lane steering and load extraction.
// Ports       : lsu_* - core side (cmd/addr/wdata/rnw in, rdata/busy/errs out)
//               dbus_* - data bus (addr/cmd/rnw/wdata/ben out,
//                        cmd_ack/rdata/rdy/err in)
// Revision    : 1.0 - initial release
// ============================================================================
module uparc_lsu
  import uparc_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic [1:0]            lsu_cmd,
  input  logic                  lsu_rnw,
  output logic                  lsu_busy,
  output logic                  lsu_err_align,
  output logic                  lsu_err_bus,
  output logic [ADDR_WIDTH-1:0] dbus_addr,
  output logic                  dbus_cmd,
  output logic                  dbus_rnw,
  output logic [DATA_WIDTH-1:0] dbus_wdata,
  output logic [3:0]            dbus_ben,
  input  logic                  dbus_cmd_ack,
  input  logic [DATA_WIDTH-1:0] dbus_rdata,
  input  logic                  dbus_rdy,
  input  logic                  dbus_err
);

  logic [1:0]            r_state;
  logic [1:0]            r_size;
  logic [1:0]            r_off;
  logic                  w_req;
  logic                  w_aligned;
  logic                  w_start;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [3:0]            w_ben;
  logic [DATA_WIDTH-1:0] w_ld_rdata;

  uparc_lsu_lanes u_lanes (
    .st_size      (lsu_cmd),
    .st_off       (lsu_addr[1:0]),
    .st_wdata     (lsu_wdata),
    .bus_wdata    (w_wdata),
    .bus_ben      (w_ben),
    .ld_size      (r_size),
    .ld_off       (r_off),
    .ld_bus_rdata (dbus_rdata),
    .ld_rdata     (w_ld_rdata)
  );

  // Commands are only looked at in IDLE; the producer is stalled otherwise.
  assign w_req         = (r_state == LSU_ST_IDLE) && (lsu_cmd != LSU_IDLE);
  assign w_aligned     = lsu_aligned(lsu_cmd, lsu_addr[1:0]);
  assign w_start       = w_req && w_aligned;
  assign lsu_err_align = w_req && !w_aligned;
  assign lsu_busy      = w_start || (r_state != LSU_ST_IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= LSU_ST_IDLE;
      r_size      <= LSU_IDLE;
      r_off       <= 2'b00;
      lsu_rdata   <= '0;
      lsu_err_bus <= 1'b0;
      dbus_addr   <= '0;
      dbus_cmd    <= 1'b0;
      dbus_rnw    <= 1'b0;
      dbus_wdata  <= '0;
      dbus_ben    <= 4'b0000;
    end else begin
      // Bus error indication is a single-cycle pulse.
      lsu_err_bus <= 1'b0;
      case (r_state)
        LSU_ST_IDLE: begin
          if (w_start) begin
            dbus_addr  <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
            dbus_cmd   <= 1'b1;
            dbus_rnw   <= lsu_rnw;
            dbus_wdata <= w_wdata;
            dbus_ben   <= w_ben;
            r_size     <= lsu_cmd;
            r_off      <= lsu_addr[1:0];
            r_state    <= LSU_ST_CMD;
          end
        end
        LSU_ST_CMD: begin
          if (dbus_cmd_ack) begin
            dbus_cmd <= 1'b0;
            r_state  <= LSU_ST_DATA;
          end
        end
        LSU_ST_DATA: begin
          // Error wins over rdy when both are asserted.
          if (dbus_err) begin
            lsu_err_bus <= 1'b1;
            r_state     <= LSU_ST_IDLE;
          end else if (dbus_rdy) begin
            if (dbus_rnw) begin
              lsu_rdata <= w_ld_rdata;
            end
            r_state <= LSU_ST_IDLE;
          end
        end
        default: begin
          r_state <= LSU_ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uparc_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_uparc_lsu
// Description : Self-checking bench for uparc_lsu. Directed scenarios plus
//               randomized operations against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uparc_lsu;

  logic        clk;
  logic        nrst;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_cmd;
  logic        lsu_rnw;
  logic        lsu_busy;
  logic        lsu_err_align;
  logic        lsu_err_bus;
  logic [31:0] dbus_addr;
  logic        dbus_cmd;
  logic        dbus_rnw;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_ben;
  logic        dbus_cmd_ack;
  logic [31:0] dbus_rdata;
  logic        dbus_rdy;
  logic        dbus_err;

  int total;
  int bad;
  logic [31:0] exp_rdata;

  uparc_lsu dut (
    .clk           (clk),
    .nrst          (nrst),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_rdata     (lsu_rdata),
    .lsu_cmd       (lsu_cmd),
    .lsu_rnw       (lsu_rnw),
    .lsu_busy      (lsu_busy),
    .lsu_err_align (lsu_err_align),
    .lsu_err_bus   (lsu_err_bus),
    .dbus_addr     (dbus_addr),
    .dbus_cmd      (dbus_cmd),
    .dbus_rnw      (dbus_rnw),
    .dbus_wdata    (dbus_wdata),
    .dbus_ben      (dbus_ben),
    .dbus_cmd_ack  (dbus_cmd_ack),
    .dbus_rdata    (dbus_rdata),
    .dbus_rdy      (dbus_rdy),
    .dbus_err      (dbus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- reference model: size in bytes, byte-lane view of the bus ----
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_ben(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = nbytes(sz);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  // Bus lane i carries byte (i mod size) of the store data.
  function automatic logic [31:0] m_wlanes(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(sz);
    r = 0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_extract(input logic [1:0] sz, input logic [31:0] a,
                                            input logic [31:0] rd);
    longint unsigned v;
    longint unsigned mask;
    v    = longint'(rd) >> (8 * (a % 4));
    mask = (64'd1 << (8 * nbytes(sz))) - 1;
    return 32'(v & mask);
  endfunction

  task automatic do_op(input logic [1:0] sz, input logic [31:0] addr, input logic rnw,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int ackd, input int rdyd, input logic err);
    logic        al;
    logic [3:0]  eben;
    logic [31:0] ewd;
    int          busy_cnt;
    al   = (addr % nbytes(sz)) == 0;
    eben = m_ben(sz, addr);
    ewd  = m_wlanes(sz, wd);

    @(negedge clk);
    lsu_cmd = sz; lsu_addr = addr; lsu_rnw = rnw; lsu_wdata = wd;
    #1;
    if (!al) begin
      chk("err_align", {31'd0, lsu_err_align}, 1);
      chk("busy_misal", {31'd0, lsu_busy}, 0);
      @(negedge clk);
      lsu_cmd = 0; lsu_addr = $urandom;
      #1;
      chk("dbus_cmd_misal", {31'd0, dbus_cmd}, 0);
      chk("busy_after_misal", {31'd0, lsu_busy}, 0);
      chk("err_align_clr", {31'd0, lsu_err_align}, 0);
      return;
    end
    chk("err_align_ok", {31'd0, lsu_err_align}, 0);
    busy_cnt = int'(lsu_busy);

    @(negedge clk);
    lsu_cmd = 0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_rnw = $urandom;
    for (int k = 0; k <= ackd; k++) begin
      if (k > 0) @(negedge clk);
      dbus_cmd_ack = (k == ackd);
      #1;
      chk("dbus_cmd", {31'd0, dbus_cmd}, 1);
      chk("dbus_addr", dbus_addr, addr & 32'hFFFF_FFFC);
      chk("dbus_ben", {28'd0, dbus_ben}, {28'd0, eben});
      chk("dbus_wdata", dbus_wdata, ewd);
      chk("dbus_rnw", {31'd0, dbus_rnw}, {31'd0, rnw});
      busy_cnt += int'(lsu_busy);
    end

    for (int j = 0; j <= rdyd; j++) begin
      @(negedge clk);
      dbus_cmd_ack = 0;
      dbus_err     = (j == rdyd) && err;
      dbus_rdy     = (j == rdyd) && (err ? logic'($urandom_range(1)) : 1'b1);
      dbus_rdata   = (j == rdyd) ? rd : $urandom;
      #1;
      chk("dbus_cmd_data", {31'd0, dbus_cmd}, 0);
      busy_cnt += int'(lsu_busy);
    end

    @(negedge clk);
    dbus_rdy = 0; dbus_err = 0; dbus_rdata = $urandom;
    if (rnw && !err) exp_rdata = m_extract(sz, addr, rd);
    #1;
    chk("busy_end", {31'd0, lsu_busy}, 0);
    chk("busy_len", busy_cnt, 3 + ackd + rdyd);
    chk("lsu_rdata", lsu_rdata, exp_rdata);
    chk("err_bus", {31'd0, lsu_err_bus}, {31'd0, err});
    @(negedge clk);
    #1;
    chk("err_bus_pulse", {31'd0, lsu_err_bus}, 0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    total = 0; bad = 0; exp_rdata = 0;
    nrst = 0; lsu_addr = 0; lsu_wdata = 0; lsu_cmd = 0; lsu_rnw = 0;
    dbus_cmd_ack = 0; dbus_rdata = 0; dbus_rdy = 0; dbus_err = 0;
    #1;
    chk("rst_rdata", lsu_rdata, 0);
    chk("rst_busy", {31'd0, lsu_busy}, 0);
    chk("rst_dbus_cmd", {31'd0, dbus_cmd}, 0);
    chk("rst_ben", {28'd0, dbus_ben}, 0);
    chk("rst_err_bus", {31'd0, lsu_err_bus}, 0);
    @(negedge clk); @(negedge clk);
    nrst = 1;

    // directed scenarios
    do_op(2'd3, 32'h100, 1, 32'h0,      32'hDEADBEEF, 0, 0, 0);
    do_op(2'd1, 32'h203, 0, 32'hA5,     32'h0,        0, 0, 0);
    do_op(2'd2, 32'h302, 1, 32'h0,      32'h80011234, 2, 0, 0);
    do_op(2'd2, 32'h101, 1, 32'h0,      32'h0,        0, 0, 0);
    do_op(2'd3, 32'h102, 0, 32'h0,      32'h0,        0, 0, 0);
    do_op(2'd3, 32'h010, 1, 32'h0,      32'h12345678, 0, 1, 1);

    // reset during DATA
    @(negedge clk);
    lsu_cmd = 2'd3; lsu_addr = 32'h40; lsu_rnw = 1;
    @(negedge clk);
    lsu_cmd = 0; dbus_cmd_ack = 1;
    @(negedge clk);
    dbus_cmd_ack = 0;
    #1;
    chk("busy_in_data", {31'd0, lsu_busy}, 1);
    nrst = 0;
    #1;
    chk("rst_data_busy", {31'd0, lsu_busy}, 0);
    chk("rst_data_cmd", {31'd0, dbus_cmd}, 0);
    chk("rst_data_addr", dbus_addr, 0);
    chk("rst_data_rdata", lsu_rdata, 0);
    exp_rdata = 0;
    @(negedge clk);
    nrst = 1;
    do_op(2'd1, 32'h45, 1, 32'h0, 32'hCAFEF00D, 0, 0, 0);

    // randomized operations
    for (int n = 0; n < 80; n++) begin
      sz = 2'($urandom_range(3, 1));
      a  = $urandom;
      do_op(sz, a, logic'($urandom_range(1)), $urandom, $urandom,
            $urandom_range(2), $urandom_range(2), ($urandom_range(4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
